// File: rtl/stopwatch_uart_reporter.sv
// Snapshots the stopwatch digits on request and transmits "D3D2.D1D0\r\n" as 8N1 UART, LSB first.
// Optional macro STOPWATCH_UART_AUTO_REPORT_EN: also report whenever the digits differ from the last report.
module stopwatch_uart_reporter #(
  parameter int CLK_FREQ = 100000000,
  parameter int BAUD     = 115200
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [3:0] i_d3,
  input  logic [3:0] i_d2,
  input  logic [3:0] i_d1,
  input  logic [3:0] i_d0,
  input  logic       i_send,
  output logic       o_tx,
  output logic       o_busy,
  output logic       o_done,
  output logic [1:0] o_dbg_state
);

  localparam int BAUD_DIV = CLK_FREQ / BAUD;
  localparam int CW       = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  function automatic logic [7:0] digit_char(input logic [3:0] v);
    logic [7:0] c;
    if (v < 4'd10) c = {4'h3, v};
    else           c = 8'h37 + {4'h0, v};
    return c;
  endfunction

  function automatic logic [7:0] msg_byte(input logic [15:0] snap, input logic [2:0] idx);
    logic [7:0] b;
    case (idx)
      3'd0:    b = digit_char(snap[15:12]);
      3'd1:    b = digit_char(snap[11:8]);
      3'd2:    b = 8'h2E;
      3'd3:    b = digit_char(snap[7:4]);
      3'd4:    b = digit_char(snap[3:0]);
      3'd5:    b = 8'h0D;
      default: b = 8'h0A;
    endcase
    return b;
  endfunction

  state_t          state_q, state_d;
  logic [CW-1:0]   baud_q, baud_d;
  logic [2:0]      char_q, char_d;
  logic [2:0]      bit_q, bit_d;
  logic [15:0]     snap_q, snap_d;
  logic            tx_q, tx_d;
  logic            done_q, done_d;
  logic [7:0]      tx_byte;
  logic [15:0]     digits;
  logic            baud_last;
  logic            start_req;

  assign digits    = {i_d3, i_d2, i_d1, i_d0};
  assign baud_last = (baud_q == BAUD_LAST);

  // Request handshake: i_send is a level request taken only on an IDLE cycle
  // (o_busy low); anything seen while o_busy is high is dropped, never queued.
`ifdef STOPWATCH_UART_AUTO_REPORT_EN
  logic [15:0] last_sent_q, last_sent_d;
  assign start_req = i_send || (digits != last_sent_q);
`else
  assign start_req = i_send;
`endif

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    char_d  = char_q;
    bit_d   = bit_q;
    snap_d  = snap_q;
    done_d  = 1'b0;
`ifdef STOPWATCH_UART_AUTO_REPORT_EN
    last_sent_d = last_sent_q;
`endif
    // Every bit period restarts the counter, so the last cycle of a bit is the boundary.
    if (state_q != S_IDLE) begin
      baud_d = baud_last ? '0 : baud_q + CW'(1);
    end

    case (state_q)
      S_IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        if (start_req) begin
          snap_d  = digits;
          char_d  = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (baud_last) begin
          bit_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (baud_last) begin
          if (bit_q == 3'd7) state_d = S_STOP;
          else               bit_d   = bit_q + 3'd1;
        end
      end
      S_STOP: begin
        if (baud_last) begin
          if (char_q == 3'd6) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
`ifdef STOPWATCH_UART_AUTO_REPORT_EN
            last_sent_d = snap_q;
`endif
          end else begin
            char_d  = char_q + 3'd1;
            state_d = S_START;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // The line is driven from a flop, so it reflects the state being entered.
    tx_byte = msg_byte(snap_d, char_d);
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = tx_byte[bit_d];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      char_q  <= '0;
      bit_q   <= '0;
      snap_q  <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
`ifdef STOPWATCH_UART_AUTO_REPORT_EN
      last_sent_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      char_q  <= char_d;
      bit_q   <= bit_d;
      snap_q  <= snap_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
`ifdef STOPWATCH_UART_AUTO_REPORT_EN
      last_sent_q <= last_sent_d;
`endif
    end
  end

  assign o_tx        = tx_q;
  assign o_busy      = (state_q != S_IDLE);
  assign o_done      = done_q;
  assign o_dbg_state = state_q;

endmodule

// File: doc/stopwatch_uart_reporter.md
Name: stopwatch_uart_reporter

Overview:
Downstream consumer of the stopwatch digit outputs (d3..d0), in parallel with the seven-segment mux.
On request, snapshots the four digits and transmits them as an ASCII line "D3D2.D1D0\r\n" over an 8N1 UART TX pin (routed to a PMOD JA pin).
Used for logging and scope/terminal debug of the keyboard-controlled stopwatch.

Parameters:
CLK_FREQ, 100000000, input clock frequency in Hz
BAUD, 115200, UART bit rate; BAUD_DIV = CLK_FREQ/BAUD (integer division, must be >= 2) clock cycles per bit

Ports:
i_clk  input  1  system clock; all logic on rising edge
i_reset  input  1  synchronous, active-high reset
i_d3  input  4  stopwatch digit 3 (most significant)
i_d2  input  4  stopwatch digit 2
i_d1  input  4  stopwatch digit 1
i_d0  input  4  stopwatch digit 0
i_send  input  1  report request; level sampled every cycle
o_tx  output  1  UART serial out, idle high
o_busy  output  1  high while a report is in progress
o_done  output  1  one-cycle pulse when a report completes

Behaviour:
- One clock, i_clk. Reset is synchronous and active-high on i_reset and overrides everything.
- Reset values: o_tx=1, o_busy=0, o_done=0, FSM=IDLE, baud counter=0, char index=0, bit index=0, snapshot=0, last_sent=0.
- FSM states: IDLE, START, DATA, STOP.
- Acceptance:
  - In IDLE, i_send=1 at an edge latches {i_d3,i_d2,i_d1,i_d0} into the snapshot.
  - At that edge: char index=0, FSM goes to START, o_busy goes 1.
  - o_tx drops low in the cycle after the accepting edge.
- i_send while not in IDLE is ignored; requests are not queued.
- Digit changes after acceptance do not affect the message; only the snapshot is used.
- Message: 7 bytes, in this order:
  - char(d3), char(d2), 0x2E '.', char(d1), char(d0), 0x0D, 0x0A.
- Digit encoding:
  - v 0..9 -> 0x30+v.
  - v 10..15 -> 0x41+(v-10), i.e. hex 'A'..'F'.
- Frame format: 8N1, LSB first.
  - Start bit 0, then 8 data bits, then stop bit 1.
  - Each bit is held exactly BAUD_DIV cycles, timed by a counter that restarts at every bit boundary.
- Byte spacing: the next byte's start bit immediately follows the previous stop bit, with no idle gap.
- Report duration: 70*BAUD_DIV cycles from the first cycle of o_tx low to the end of the final stop bit.
- Completion:
  - At the edge ending the last stop bit of byte 6, FSM returns to IDLE.
  - In the following cycle o_busy=0 and o_done=1, for exactly one cycle.
  - A new i_send in that cycle is accepted normally.
- last_sent is updated with the snapshot at completion.
- Reset mid-report: the frame is abandoned. On the next edge o_tx=1 and o_busy=0, with no o_done pulse.

Optional Feature:
Macro: STOPWATCH_UART_AUTO_REPORT_EN
- Defined:
  - In IDLE, a report is also triggered automatically when {i_d3,i_d2,i_d1,i_d0} != last_sent.
  - Snapshot, timing and completion are identical to an i_send-triggered report.
  - i_send still works and forces a report even when the digits are unchanged.
  - Changes that occur during a report are caught on the first IDLE cycle after it.
- Not defined: the last_sent compare logic is absent and reports start only on i_send.

Test Plan:
1. Params CLK_FREQ=1000, BAUD=100 (BAUD_DIV=10). Assert i_reset 3 cycles -> o_tx=1, o_busy=0, o_done=0; o_tx stays high 100 cycles with i_send=0.
2. Digits 1,2,3,4, pulse i_send 1 cycle -> bytes decoded 0x31,0x32,0x2E,0x33,0x34,0x0D,0x0A:
   - each bit 10 cycles wide; o_tx low 1 cycle after the accept;
   - o_done a single pulse 700 cycles after the first low cycle; o_busy falls in the o_done cycle.
3. Digits A,F,0,9 -> bytes 0x41,0x46,0x2E,0x30,0x39,0x0D,0x0A.
4. Digits 5,6,7,8, send, then change digits to 0,0,0,0 and pulse i_send at cycle 200 -> output still 0x35,0x36,0x2E,0x37,0x38,0x0D,0x0A; only one o_done pulse.
5. Assert i_reset at cycle 350 of a report -> o_tx=1 and o_busy=0 next cycle, no o_done; a fresh i_send afterwards produces a full correct message.
6. With STOPWATCH_UART_AUTO_REPORT_EN: after reset set digits to 0,0,1,5 with no i_send -> report "00.15\r\n" starts automatically. Holding the digits unchanged -> no further report.
